// File: rtl/instr_fetch_if.sv
// Bundle of instruction-memory, control and decode-handshake signals for instr_fetch.
// master = fetch unit, slave = memory/execute/decode side.
interface instr_fetch_if #(
  parameter int unsigned AW = 8
) ();
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [7:0]    mem_data;
  logic          halt;
  logic          jump;
  logic [AW-1:0] jump_target;
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;

  modport master (
    output mem_addr, mem_re, instr_valid, instr, instr_pc,
    input  mem_data, halt, jump, jump_target, instr_ready
  );

  modport slave (
    input  mem_addr, mem_re, instr_valid, instr, instr_pc,
    output mem_data, halt, jump, jump_target, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Two-byte instruction fetch unit: reads {high, low} bytes from a byte-wide memory
// and holds the assembled instruction until the decode stage accepts it.
module instr_fetch #(
  parameter int unsigned   AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    HOLD     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic [15:0]   instr_q, instr_d;
  logic          mem_re_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= FETCH_HI;
    else       state_q <= state_d;
  end

  // A redirect always restarts at the high byte, whatever else is happening.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_HI: if (!bus.halt)       state_d = FETCH_LO;
      FETCH_LO: if (!bus.halt)       state_d = HOLD;
      HOLD:     if (bus.instr_ready) state_d = FETCH_HI;
      default:                       state_d = FETCH_HI;
    endcase
    if (bus.jump) state_d = FETCH_HI;
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    mem_re_c   = 1'b0;
    unique case (state_q)
      FETCH_HI: begin
        mem_re_c = !bus.halt;
        if (!bus.halt) begin
          instr_d[15:8] = bus.mem_data;
          instr_pc_d    = pc_q;
          pc_d          = pc_q + AW'(1);
        end
      end
      FETCH_LO: begin
        mem_re_c = !bus.halt;
        if (!bus.halt) begin
          instr_d[7:0] = bus.mem_data;
          pc_d         = pc_q + AW'(1);
        end
      end
      default: ;
    endcase
    // Jump wins over halt and suppresses the byte latch of the discarded fetch.
    if (bus.jump) begin
      pc_d       = bus.jump_target;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign bus.mem_addr    = pc_q;
  assign bus.mem_re      = mem_re_c;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random halt/ready/jump traffic
// checked against a byte-count level model of the fetch unit.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] mem [256];

  instr_fetch_if #(.AW(8)) if0 ();
  instr_fetch_if #(.AW(8)) if1 ();

  instr_fetch #(.AW(8), .RESET_PC(8'h00)) dut0 (.clock(clk), .reset(rst), .bus(if0));
  instr_fetch #(.AW(8), .RESET_PC(8'h10)) dut1 (.clock(clk), .reset(rst), .bus(if1));

  assign if0.mem_data    = mem[if0.mem_addr];
  assign if1.mem_data    = mem[if1.mem_addr];
  assign if1.halt        = 1'b0;
  assign if1.jump        = 1'b0;
  assign if1.jump_target = 8'h00;
  assign if1.instr_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;

  always @(posedge clk) if (if0.instr_valid && if0.instr_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Reference state: how many bytes of the current instruction are gathered.
  logic [7:0]  m_pc, m_ipc, nxt;
  logic [15:0] m_instr;
  int          nb;
  int          hs_before;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
    mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
    mem[8'hFF] = 8'hAB;
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22;
    mem[8'h80] = 8'h99; mem[8'h81] = 8'h88;
    if0.halt = 1'b0; if0.jump = 1'b0; if0.jump_target = 8'h00; if0.instr_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(if0.instr_valid), 32'd0);
    chk("rst_addr",  32'(if0.mem_addr), 32'h00);
    chk("rst_instr", 32'(if0.instr), 32'h0);
    chk("rst_ipc",   32'(if0.instr_pc), 32'h0);
    rst = 1'b0;
    #1;
    chk("first_addr", 32'(if0.mem_addr), 32'h00);
    chk("first_re",   32'(if0.mem_re), 32'd1);

    // First instruction: valid on the third cycle
    cyc();
    chk("lo_addr",  32'(if0.mem_addr), 32'h01);
    chk("lo_valid", 32'(if0.instr_valid), 32'd0);
    cyc();
    chk("i0_valid", 32'(if0.instr_valid), 32'd1);
    chk("i0_instr", 32'(if0.instr), 32'h1234);
    chk("i0_ipc",   32'(if0.instr_pc), 32'h00);
    chk("i0_re",    32'(if0.mem_re), 32'd0);

    // Backpressure in HOLD
    if0.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_valid", 32'(if0.instr_valid), 32'd1);
      chk("bp_instr", 32'(if0.instr), 32'h1234);
      chk("bp_ipc",   32'(if0.instr_pc), 32'h00);
      chk("bp_re",    32'(if0.mem_re), 32'd0);
    end
    if0.instr_ready = 1'b1;
    cyc();
    chk("resume_addr", 32'(if0.mem_addr), 32'h02);
    chk("resume_re",   32'(if0.mem_re), 32'd1);

    // Halt in FETCH_HI
    if0.halt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("halt_re",   32'(if0.mem_re), 32'd0);
      chk("halt_addr", 32'(if0.mem_addr), 32'h02);
      cyc();
    end
    if0.halt = 1'b0;
    cyc();
    chk("post_halt_addr", 32'(if0.mem_addr), 32'h03);

    // Jump during FETCH_LO to the wrap-around address
    mem[8'h00] = 8'hCD;
    if0.jump = 1'b1; if0.jump_target = 8'hFF;
    cyc();
    if0.jump = 1'b0;
    chk("jmp_addr",  32'(if0.mem_addr), 32'hFF);
    chk("jmp_valid", 32'(if0.instr_valid), 32'd0);
    cyc();
    chk("wrap_addr", 32'(if0.mem_addr), 32'h00);
    cyc();
    chk("wrap_valid", 32'(if0.instr_valid), 32'd1);
    chk("wrap_instr", 32'(if0.instr), 32'hABCD);
    chk("wrap_ipc",   32'(if0.instr_pc), 32'hFF);
    cyc();
    chk("wrap_next_addr", 32'(if0.mem_addr), 32'h01);

    // Jump overrides halt
    if0.halt = 1'b1; if0.jump = 1'b1; if0.jump_target = 8'h40;
    cyc();
    if0.halt = 1'b0; if0.jump = 1'b0;
    chk("halt_jmp_addr", 32'(if0.mem_addr), 32'h40);
    cyc(); cyc();
    chk("j40_valid", 32'(if0.instr_valid), 32'd1);
    chk("j40_instr", 32'(if0.instr), 32'h1122);

    // Jump together with handshake: instruction consumed
    hs_before = hs_cnt;
    if0.jump = 1'b1; if0.jump_target = 8'h80;
    cyc();
    if0.jump = 1'b0;
    chk("jhs_valid", 32'(if0.instr_valid), 32'd0);
    chk("jhs_addr",  32'(if0.mem_addr), 32'h80);
    chk("jhs_count", 32'(hs_cnt), 32'(hs_before + 1));
    cyc(); cyc();
    chk("j80_instr", 32'(if0.instr), 32'h9988);
    chk("j80_ipc",   32'(if0.instr_pc), 32'h80);

    // Jump in HOLD without ready: instruction dropped
    hs_before = hs_cnt;
    if0.instr_ready = 1'b0; if0.jump = 1'b1; if0.jump_target = 8'h20;
    cyc();
    if0.jump = 1'b0; if0.instr_ready = 1'b1;
    chk("jdrop_valid", 32'(if0.instr_valid), 32'd0);
    chk("jdrop_addr",  32'(if0.mem_addr), 32'h20);
    chk("jdrop_count", 32'(hs_cnt), 32'(hs_before));

    // Asynchronous reset between edges during FETCH_LO
    cyc();
    chk("pre_rst_addr", 32'(if0.mem_addr), 32'h21);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(if0.instr_valid), 32'd0);
    chk("arst_addr",  32'(if0.mem_addr), 32'h00);
    chk("arst_instr", 32'(if0.instr), 32'h0);
    chk("arst_ipc",   32'(if0.instr_pc), 32'h0);
    chk("arst1_addr", 32'(if1.mem_addr), 32'h10);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rpc_re",   32'(if1.mem_re), 32'd1);
    chk("rpc_addr", 32'(if1.mem_addr), 32'h10);
    cyc(); cyc();
    chk("rpc_valid", 32'(if1.instr_valid), 32'd1);
    chk("rpc_ipc",   32'(if1.instr_pc), 32'h10);

    // Random traffic against the model
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    m_pc = 8'h00; m_ipc = 8'h00; m_instr = 16'h0; nb = 0;
    for (int c = 0; c < 400; c++) begin
      if0.halt        = ($urandom_range(0, 3) == 0);
      if0.instr_ready = ($urandom_range(0, 2) != 0);
      if0.jump        = ($urandom_range(0, 9) == 0);
      if0.jump_target = 8'($urandom);
      #1;
      chk("r_addr",  32'(if0.mem_addr), 32'(m_pc));
      chk("r_re",    32'(if0.mem_re), 32'((nb < 2) && !if0.halt));
      chk("r_valid", 32'(if0.instr_valid), 32'(nb == 2));
      if (nb == 2) begin
        chk("r_instr", 32'(if0.instr), 32'(m_instr));
        chk("r_ipc",   32'(if0.instr_pc), 32'(m_ipc));
        if (if0.instr_ready) begin
          nxt = m_ipc + 8'd1;
          chk("r_stream", 32'(if0.instr), 32'({mem[m_ipc], mem[nxt]}));
        end
      end
      if (if0.jump) begin
        m_pc = if0.jump_target;
        nb   = 0;
      end else if (nb == 2) begin
        if (if0.instr_ready) nb = 0;
      end else if (!if0.halt) begin
        if (nb == 0) begin
          m_ipc          = m_pc;
          m_instr[15:8]  = mem[m_pc];
        end else begin
          m_instr[7:0]   = mem[m_pc];
        end
        m_pc = m_pc + 8'd1;
        nb++;
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter AW, 8, byte address width of instruction memory (memory is 2**AW bytes).
REQ-002 Parameter RESET_PC, 0, PC value loaded on reset.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_addr  output  AW  byte address to instruction memory.
REQ-006 mem_re  output  1  read enable to instruction memory.
REQ-007 mem_data  input  8  memory read data, combinationally valid in the same cycle as mem_addr/mem_re.
REQ-008 halt  input  1  when 1, fetch activity freezes.
REQ-009 jump  input  1  redirect request from execute stage.
REQ-010 jump_target  input  AW  new PC on redirect.
REQ-011 instr_valid  output  1  instr/instr_pc hold a complete instruction.
REQ-012 instr_ready  input  1  downstream decode/ALU stage accepts instruction.
REQ-013 instr  output  16  fetched instruction, {high byte, low byte}.
REQ-014 instr_pc  output  AW  byte address of the instruction's high byte.

Function
REQ-015 The block SHALL implement an FSM with states FETCH_HI, FETCH_LO, HOLD, plus an AW-bit PC register.
REQ-016 FETCH_HI: mem_addr = pc, mem_re = ~halt; if ~halt, the clock edge SHALL latch mem_data into instr[15:8], latch pc into instr_pc, set pc <= pc+1, and move to FETCH_LO.
REQ-017 FETCH_LO: mem_addr = pc, mem_re = ~halt; if ~halt, the clock edge SHALL latch mem_data into instr[7:0], set pc <= pc+1, and move to HOLD.
REQ-018 HOLD: instr_valid = 1, mem_re = 0; instr/instr_pc SHALL stay stable until handshake (instr_valid & instr_ready) completes, then the FSM SHALL move to FETCH_HI.
REQ-019 instr_valid SHALL be 1 only in HOLD; it is a registered state decode, not combinational on inputs.
REQ-020 With halt=0, instr_ready=1, and no jump, each instruction SHALL take 3 cycles: 2 fetch cycles, then 1 HOLD cycle.
REQ-021 halt in HOLD SHALL have no effect; the handshake still completes.
REQ-022 halt in a fetch state SHALL hold state, pc, and instr unchanged with mem_re=0.
REQ-023 PC arithmetic SHALL be modulo 2**AW: pc 0xFF+1 = 0x00 for AW=8.
REQ-024 An instruction at 0xFF SHALL take its low byte from 0x00.
REQ-025 jump=1 in any state SHALL set pc <= jump_target and state <= FETCH_HI at that edge, overriding halt and any fetch latch.
REQ-026 On a jump, a partially fetched instruction SHALL be discarded.
REQ-027 If jump and a HOLD handshake occur in the same cycle, the handshake SHALL count as completed (instruction consumed), then the redirect SHALL apply.
REQ-028 If jump occurs in HOLD without instr_ready, the held instruction SHALL be dropped and instr_valid SHALL be 0 the next cycle.
REQ-029 The bytes at jump_target SHALL be fetched with no extra bubble beyond the 2 fetch cycles.
REQ-030 mem_addr SHALL equal pc in all states; only mem_re qualifies the access.

Reset
REQ-031 reset=1 SHALL asynchronously force state=FETCH_HI, pc=RESET_PC, instr=0, instr_pc=0, and instr_valid=0.
REQ-032 Reset asserted mid-fetch or in HOLD SHALL discard the in-flight instruction.
REQ-033 The first fetch SHALL occur at RESET_PC on the first posedge after reset deasserts.

Verification
REQ-034 Memory 0x00=0x12, 0x01=0x34, ready=1 after reset -> instr_valid=1 in cycle 3, instr=0x1234, instr_pc=0x00; next instr_pc=0x02.
REQ-035 instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1 and instr/instr_pc are constant; mem_re=0 throughout; fetch at pc=0x02 resumes the cycle after ready=1.
REQ-036 jump=1, jump_target=0xFF while in FETCH_LO; memory 0xFF=0xAB, 0x00=0xCD -> the partial instruction is dropped; next instr=0xABCD, instr_pc=0xFF; following fetch at pc=0x01.
REQ-037 halt=1 for 3 cycles in FETCH_HI -> mem_re=0 and no pc change; halt=1 with jump=1 -> pc=jump_target.
REQ-038 jump with instr_valid=1 and instr_ready=1 in the same cycle -> one instruction is counted as consumed, the next is from jump_target; jump with ready=0 -> instr_valid=0 next cycle.
REQ-039 reset pulsed asynchronously between clock edges during FETCH_LO -> outputs reach their reset values immediately; with RESET_PC=0x10, the first mem_re access is at 0x10.
